// File: rtl/mips32_pkg.sv
// Shared MIPS32 constants and types: opcodes, instruction classes and the
// fetch-queue state encoding.
package mips32_pkg;

  localparam int WORD_W     = 32;
  localparam int DEFAULT_AW = 10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  typedef enum logic [2:0] {
    RR_ALU,
    RM_ALU,
    LOAD,
    STORE,
    BRANCH,
    HALT
  } instr_type_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT_RSP,
    ST_DISCARD
  } fetch_state_e;

  // Coarse class of an instruction word, used by decode-side consumers.
  function automatic instr_type_e decode_type(input logic [WORD_W-1:0] ir);
    instr_type_e t;
    t = RR_ALU;
    case (ir[31:26])
      OP_RTYPE:                            t = RR_ALU;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:   t = RM_ALU;
      OP_LW:                               t = LOAD;
      OP_SW:                               t = STORE;
      OP_BEQ, OP_BNE, OP_J:                t = BRANCH;
      OP_HLT:                              t = HALT;
      default:                             t = RR_ALU;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mips32_sync_fifo.sv
// Small synchronous FIFO with flush; the head word is a registered read of
// the storage array, bypassed from the push port when it lands at the head.
module mips32_sync_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               push_data_i,
  input  logic                           pop_i,
  input  logic                           flush_i,
  output logic [WIDTH-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    head_d   = head_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (count_d != '0) begin
      // The new head is the incoming word when it is written into the head slot.
      head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data_i : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction fetch front-end: one outstanding imem request, prefetch
// FIFO of {instruction, npc} toward decode, branch redirect and sticky halt.
module mips32_fetch_queue
  import mips32_pkg::*;
#(
  parameter int            DEPTH    = 4,
  parameter int            AW       = DEFAULT_AW,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                        clk1,
  input  logic                        rst_n,
  output logic                        imem_req_valid,
  output logic [AW-1:0]               imem_req_addr,
  input  logic                        imem_req_ready,
  input  logic                        imem_rsp_valid,
  input  logic [WORD_W-1:0]           imem_rsp_data,
  input  logic                        redirect_valid,
  input  logic [AW-1:0]               redirect_pc,
  input  logic                        halt,
  output logic                        if_valid,
  input  logic                        if_ready,
  output logic [WORD_W-1:0]           if_ir,
  output logic [WORD_W-1:0]           if_npc,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = WORD_W + AW;

  fetch_state_e  state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] req_npc_q;
  logic          halted_q;

  logic          has_room;
  logic          accept;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  assign has_room = fifo_count < CW'(DEPTH);

  // Gating with rst_n keeps the request low while reset is held.
  assign imem_req_valid = rst_n && (state_q == ST_RUN) && !halted_q &&
                          !redirect_valid && has_room;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign push = (state_q == ST_WAIT_RSP) && imem_rsp_valid && !redirect_valid;
  assign pop  = if_valid && if_ready;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      req_npc_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      if (halt) begin
        halted_q <= 1'b1;
      end
      if (redirect_valid) begin
        pc_q <= redirect_pc;
      end else if (accept) begin
        pc_q <= pc_q + AW'(1);
      end
      if (accept) begin
        req_npc_q <= pc_q + AW'(1);
      end
      unique case (state_q)
        ST_RUN: begin
          if (accept) state_q <= ST_WAIT_RSP;
        end
        ST_WAIT_RSP: begin
          // A response coinciding with a redirect is simply dropped.
          if (imem_rsp_valid)      state_q <= ST_RUN;
          else if (redirect_valid) state_q <= ST_DISCARD;
        end
        ST_DISCARD: begin
          if (imem_rsp_valid) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  mips32_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk1),
    .rst_ni      (rst_n),
    .push_i      (push),
    .push_data_i ({imem_rsp_data, req_npc_q}),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign if_valid = (fifo_count != '0);
  assign if_ir    = head[EW-1:AW];
  assign if_npc   = WORD_W'(head[AW-1:0]);

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Bench for mips32_fetch_queue: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_mips32_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 10;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b1;
  logic          imem_req_valid;
  logic [AW-1:0] imem_req_addr;
  logic          imem_req_ready = 1'b1;
  logic          imem_rsp_valid = 1'b0;
  logic [31:0]   imem_rsp_data = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          halt = 1'b0;
  logic          if_valid;
  logic          if_ready = 1'b1;
  logic [31:0]   if_ir;
  logic [31:0]   if_npc;
  logic [2:0]    fifo_count;

  always #5 clk1 = ~clk1;

  mips32_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .RESET_PC('0)) dut (
    .clk1           (clk1),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_ir          (if_ir),
    .if_npc         (if_npc),
    .fifo_count     (fifo_count)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: queue of delivered words plus fetch bookkeeping.
  typedef struct {
    logic [31:0] ir;
    logic [31:0] npc;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc = 0;
  logic [31:0] m_req_npc = 0;
  int          m_outst = 0;      // 0 none, 1 live, 2 wrong-path
  bit          m_halted = 0;
  logic [31:0] hold_ir = 0;
  logic [31:0] hold_npc = 0;

  // Memory environment.
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 0;
  int          lat_lo = 1, lat_hi = 1;
  int          rdy_pct = 100, ifr_pct = 100;
  bit          junk_en = 0;
  logic [31:0] mem_key = 0;

  logic [31:0] acc_log[$];
  logic [31:0] pop_ir[$];
  logic [31:0] pop_npc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (32'h1000 + a) ^ mem_key;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_pc = 0;
    m_req_npc = 0;
    m_outst = 0;
    m_halted = 0;
    hold_ir = 0;
    hold_npc = 0;
  endfunction

  function automatic void model_step(input bit acc, input bit pop);
    ent_t e;
    if (pop) void'(mq.pop_front());
    if (imem_rsp_valid && m_outst != 0) begin
      if (m_outst == 1 && !redirect_valid) begin
        e.ir  = imem_rsp_data;
        e.npc = m_req_npc;
        mq.push_back(e);
      end
      m_outst = 0;
    end
    if (redirect_valid) begin
      mq.delete();
      if (m_outst == 1) m_outst = 2;
    end
    if (acc) begin
      m_outst   = 1;
      m_pc      = (m_pc + 1) % (1 << AW);
      m_req_npc = m_pc;
    end
    if (redirect_valid) m_pc = 32'(redirect_pc);
    if (halt) m_halted = 1;
    if (mq.size() != 0) begin
      hold_ir  = mq[0].ir;
      hold_npc = mq[0].npc;
    end
  endfunction

  // One clock: compare, advance model, cross the edge, drive next inputs.
  task automatic tick();
    bit          mv, acc, pop;
    logic [31:0] aaddr;
    #1;
    acc   = 0;
    aaddr = m_pc;
    if (!rst_n) begin
      check("rst_req_valid", 32'(imem_req_valid), 0);
      check("rst_req_addr", 32'(imem_req_addr), 0);
      check("rst_if_valid", 32'(if_valid), 0);
      check("rst_if_ir", if_ir, 0);
      check("rst_if_npc", if_npc, 0);
      check("rst_count", 32'(fifo_count), 0);
      model_reset();
    end else begin
      mv = (m_outst == 0) && !m_halted && !redirect_valid && (mq.size() < DEPTH);
      check("req_valid", 32'(imem_req_valid), 32'(mv));
      check("req_addr", 32'(imem_req_addr), m_pc);
      check("if_valid", 32'(if_valid), 32'(mq.size() != 0));
      check("if_ir", if_ir, (mq.size() != 0) ? mq[0].ir : hold_ir);
      check("if_npc", if_npc, (mq.size() != 0) ? mq[0].npc : hold_npc);
      check("count", 32'(fifo_count), 32'(mq.size()));
      acc = mv && imem_req_ready;
      pop = (mq.size() != 0) && if_ready;
      if (acc) acc_log.push_back(aaddr);
      if (pop) begin
        $display("[TB] pop ir=%h npc=%h", mq[0].ir, mq[0].npc);
        pop_ir.push_back(mq[0].ir);
        pop_npc.push_back(mq[0].npc);
      end
      model_step(acc, pop);
    end
    @(posedge clk1);
    @(negedge clk1);
    redirect_valid = 1'b0;
    halt           = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (acc) begin
      mem_pend = 1;
      mem_cnt  = $urandom_range(lat_hi, lat_lo);
      mem_addr = aaddr;
    end
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
        mem_pend       = 0;
      end
    end else if (junk_en && $urandom_range(9) == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
    end
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    if_ready       = ($urandom_range(99) < ifr_pct);
  endtask

  task automatic wait_outstanding(input string tag);
    for (int i = 0; i < 40 && m_outst != 1; i++) tick();
    check(tag, 32'(m_outst), 1);
  endtask

  initial begin
    logic [31:0] exp_npc;
    #2 rst_n = 1'b0;
    @(negedge clk1);
    repeat (2) tick();
    rst_n = 1'b1;

    // Sequential fetch, 1-cycle memory, decode always ready.
    acc_log.delete();
    repeat (20) tick();
    check("t1_first_addr", acc_log.size() != 0 ? acc_log[0] : 32'hFFFF_FFFF, 0);
    check("t1_second_addr", acc_log.size() > 1 ? acc_log[1] : 32'hFFFF_FFFF, 1);
    check("t1_first_ir", pop_ir.size() != 0 ? pop_ir[0] : 32'hFFFF_FFFF, 32'h1000);
    check("t1_first_npc", pop_npc.size() != 0 ? pop_npc[0] : 32'hFFFF_FFFF, 1);

    // Decode stalls: FIFO fills, requests stop, then drains in order.
    ifr_pct = 0;
    if_ready = 1'b0;
    repeat (20) tick();
    #1;
    check("t2_full", 32'(fifo_count), DEPTH);
    check("t2_no_req", 32'(imem_req_valid), 0);
    ifr_pct = 100;
    if_ready = 1'b1;
    repeat (12) tick();

    // Wrap-around: redirect to the last word.
    redirect_valid = 1'b1;
    redirect_pc    = 10'd1023;
    tick();
    acc_log.delete();
    pop_npc.delete();
    repeat (12) tick();
    check("t6_nreq", 32'(acc_log.size() >= 2), 1);
    if (acc_log.size() >= 2) begin
      check("t6_req0", acc_log[0], 1023);
      check("t6_req1", acc_log[1], 0);
    end
    check("t6_npops", 32'(pop_npc.size() >= 2), 1);
    if (pop_npc.size() >= 2) begin
      check("t6_npc0", pop_npc[0], 0);
      check("t6_npc1", pop_npc[1], 1);
    end

    // Redirect with a 3-cycle memory while a request is outstanding.
    lat_lo = 3; lat_hi = 3;
    wait_outstanding("t3_wait");
    redirect_valid = 1'b1;
    redirect_pc    = 10'h20;
    tick();
    acc_log.delete();
    pop_npc.delete();
    pop_ir.delete();
    repeat (15) tick();
    check("t3_req0", acc_log.size() != 0 ? acc_log[0] : 32'hFFFF_FFFF, 32'h20);
    check("t3_npc0", pop_npc.size() != 0 ? pop_npc[0] : 32'hFFFF_FFFF, 32'h21);
    check("t3_ir0", pop_ir.size() != 0 ? pop_ir[0] : 32'hFFFF_FFFF, 32'h1020);

    // Randomized traffic with redirects and stray responses.
    lat_lo = 1; lat_hi = 4;
    rdy_pct = 70; ifr_pct = 60;
    junk_en = 1;
    mem_key = $urandom;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 3) begin
        redirect_valid = 1'b1;
        redirect_pc    = 10'($urandom_range(1023));
      end
      tick();
    end
    junk_en = 0;
    mem_key = 0;
    rdy_pct = 100; ifr_pct = 100;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    repeat (10) tick();

    // Reset while a request is outstanding; the late response is ignored.
    lat_lo = 3; lat_hi = 3;
    wait_outstanding("t5_wait");
    rdy_pct = 0;
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_async_req_valid", 32'(imem_req_valid), 0);
    check("t5_async_if_valid", 32'(if_valid), 0);
    check("t5_async_count", 32'(fifo_count), 0);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("t5_late_ignored", 32'(fifo_count), 0);
    rdy_pct = 100;
    imem_req_ready = 1'b1;
    acc_log.delete();
    repeat (6) tick();
    check("t5_nreq", 32'(acc_log.size() != 0), 1);
    if (acc_log.size() != 0) check("t5_first_addr", acc_log[0], 0);

    // Halt while a request is outstanding; word still delivered, no more fetches.
    wait_outstanding("t4_wait");
    exp_npc = m_req_npc;
    halt = 1'b1;
    pop_npc.delete();
    acc_log.delete();
    tick();
    repeat (20) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 10'h55;
    tick();
    repeat (29) tick();
    #1;
    check("t4_no_req", 32'(imem_req_valid), 0);
    check("t4_pc_updated", 32'(imem_req_addr), 32'h55);
    check("t4_no_accepts", 32'(acc_log.size()), 0);
    check("t4_npops", 32'(pop_npc.size() != 0), 1);
    if (pop_npc.size() != 0) check("t4_last_npc", pop_npc[pop_npc.size()-1], exp_npc);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    acc_log.delete();
    repeat (6) tick();
    check("t4_resume", 32'(acc_log.size() != 0), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
